// File: rtl/fpu_wb_buffer_pkg.sv
// Shared FPU definitions: IEEE-754 single classification constants, buffer
// defaults and the FCSR sticky-bit positions consumed downstream.
package fpu_wb_buffer_pkg;

  localparam int         DEPTH_DEFAULT = 4;
  localparam int         RN_W_DEFAULT  = 5;
  localparam logic [7:0] EXP_ALL_ONES  = 8'hff;

  localparam int FCSR_NAN_BIT = 4;
  localparam int FCSR_INF_BIT = 3;

  typedef struct packed {
    logic is_nan;
    logic is_inf;
  } fp_class_t;

endpackage

// File: rtl/fpu_wb_buffer_if.sv
// Adder-result push, register-file write-back and forwarding query signals.
interface fpu_wb_buffer_if
  import fpu_wb_buffer_pkg::*;
#(
  parameter int RN_W = RN_W_DEFAULT
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_data;
  logic [RN_W-1:0] in_rd;
  logic            wb_valid;
  logic            wb_ready;
  logic [31:0]     wb_data;
  logic [RN_W-1:0] wb_rd;
  logic [RN_W-1:0] fwd_rs;
  logic            fwd_hit;
  logic [31:0]     fwd_data;

  modport master (
    output in_valid, in_data, in_rd, wb_ready, fwd_rs,
    input  in_ready, wb_valid, wb_data, wb_rd, fwd_hit, fwd_data
  );

  modport slave (
    input  in_valid, in_data, in_rd, wb_ready, fwd_rs,
    output in_ready, wb_valid, wb_data, wb_rd, fwd_hit, fwd_data
  );
endinterface

// File: rtl/fpu_wb_buffer_fp_class.sv
// Combinational NaN / infinity detection for an IEEE-754 single; sign ignored.
module fp_class
  import fpu_wb_buffer_pkg::*;
(
  input  logic [31:0] value,
  output fp_class_t   cls
);
  logic exp_ones;
  logic frac_zero;
  logic sign_unused;

  assign exp_ones    = (value[30:23] == EXP_ALL_ONES);
  assign frac_zero   = (value[22:0] == 23'd0);
  assign sign_unused = value[31];

  assign cls.is_nan = exp_ones & ~frac_zero;
  assign cls.is_inf = exp_ones & frac_zero;
endmodule

// File: rtl/fpu_wb_buffer.sv
// In-order write-back FIFO behind the FP adder with youngest-match forwarding
// and sticky NaN/inf status collected from committed results.
module fpu_wb_buffer
  import fpu_wb_buffer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int RN_W  = RN_W_DEFAULT
) (
  input  logic           clk,
  input  logic           clrn,
  fpu_wb_buffer_if.slave bus,
  input  logic           flush,
  input  logic           flag_clr,
  output logic           nan_seen,
  output logic           inf_seen
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]   rd_ptr_reg;
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW:0]     count_reg;
  logic            nan_reg;
  logic            inf_reg;
  logic [31:0]     data_mem [DEPTH];
  logic [RN_W-1:0] rd_mem   [DEPTH];

  logic            push;
  logic            pop;
  fp_class_t       head_cls;
  logic [DEPTH-1:0] age_match;
  logic [31:0]     age_data [DEPTH];
  logic            fwd_hit;
  logic [31:0]     fwd_data;

  assign bus.in_ready = (count_reg != (PW+1)'(DEPTH));
  assign bus.wb_valid = (count_reg != '0);
  assign bus.wb_data  = bus.wb_valid ? data_mem[rd_ptr_reg] : 32'd0;
  assign bus.wb_rd    = bus.wb_valid ? rd_mem[rd_ptr_reg] : '0;

  assign push = bus.in_valid & bus.in_ready & ~flush;
  assign pop  = bus.wb_valid & bus.wb_ready;

  fp_class u_head_class (
    .value (bus.wb_data),
    .cls   (head_cls)
  );

  // Entries indexed by age: gi=0 is the head, higher gi is younger.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
    logic [PW-1:0] idx;
    assign idx           = rd_ptr_reg + PW'(gi);
    assign age_match[gi] = ((PW+1)'(gi) < count_reg) && (rd_mem[idx] == bus.fwd_rs);
    assign age_data[gi]  = data_mem[idx];
  end

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = 32'd0;
    for (int k = 0; k < DEPTH; k++) begin
      if (age_match[k]) begin
        fwd_hit  = 1'b1;
        fwd_data = age_data[k];
      end
    end
  end

  assign bus.fwd_hit  = fwd_hit;
  assign bus.fwd_data = fwd_data;

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_reg] <= bus.in_data;
      rd_mem[wr_ptr_reg]   <= bus.in_rd;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      nan_reg    <= 1'b0;
      inf_reg    <= 1'b0;
    end else begin
      if (flush) begin
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
        if (push && !pop)      count_reg <= count_reg + (PW+1)'(1);
        else if (pop && !push) count_reg <= count_reg - (PW+1)'(1);
      end
      // A pop during flush still committed at the register file, so it counts.
      nan_reg <= (nan_reg & ~flag_clr) | (pop & head_cls.is_nan);
      inf_reg <= (inf_reg & ~flag_clr) | (pop & head_cls.is_inf);
    end
  end

  assign nan_seen = nan_reg;
  assign inf_seen = inf_reg;
endmodule

// File: tb/tb_fpu_wb_buffer.sv
// Randomized and directed checks of fpu_wb_buffer against a queue-based model.
module tb_fpu_wb_buffer;
  import fpu_wb_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam int RN_W  = 5;

  logic clk      = 1'b0;
  logic clrn     = 1'b1;
  logic flush    = 1'b0;
  logic flag_clr = 1'b0;
  logic nan_seen;
  logic inf_seen;

  fpu_wb_buffer_if #(.RN_W(RN_W)) bus ();

  fpu_wb_buffer #(.DEPTH(DEPTH), .RN_W(RN_W)) dut (
    .clk      (clk),
    .clrn     (clrn),
    .bus      (bus),
    .flush    (flush),
    .flag_clr (flag_clr),
    .nan_seen (nan_seen),
    .inf_seen (inf_seen)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [RN_W+31:0] mq [$];
  logic m_nan = 1'b0;
  logic m_inf = 1'b0;

  function automatic bit f_nan(logic [31:0] v);
    return (v[30:23] == 8'hff) && (v[22:0] != 23'd0);
  endfunction

  function automatic bit f_inf(logic [31:0] v);
    return (v[30:23] == 8'hff) && (v[22:0] == 23'd0);
  endfunction

  function automatic logic [32:0] m_fwd(logic [RN_W-1:0] rs);
    logic [RN_W+31:0] e;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      e = mq[i];
      if (e[RN_W+31:32] == rs) return {1'b1, e[31:0]};
    end
    return 33'd0;
  endfunction

  function automatic logic [RN_W+31:0] m_head();
    if (mq.size() == 0) return '0;
    return mq[0];
  endfunction

  function automatic logic [31:0] pick_data();
    logic [31:0] d;
    d = $urandom;
    case ($urandom_range(0, 5))
      0: d = {d[31], 8'hff, d[22:1], 1'b1};
      1: d = {d[31], 8'hff, 23'd0};
      default: if (d[30:23] == 8'hff) d[30] = 1'b0;
    endcase
    return d;
  endfunction

  task automatic set_in(input logic iv, input logic [31:0] d, input logic [RN_W-1:0] rd,
                        input logic wbr);
    bus.in_valid = iv;
    bus.in_data  = d;
    bus.in_rd    = rd;
    bus.wb_ready = wbr;
  endtask

  // Advance one clock edge and apply the buffer rules to the model.
  task automatic tick();
    bit do_push, do_pop;
    logic [RN_W+31:0] he;
    logic [31:0] hd;
    do_push = bus.in_valid && (mq.size() != DEPTH) && !flush;
    do_pop  = (mq.size() != 0) && bus.wb_ready;
    he = m_head();
    hd = he[31:0];
    @(posedge clk);
    m_nan = (m_nan && !flag_clr) || (do_pop && f_nan(hd));
    m_inf = (m_inf && !flag_clr) || (do_pop && f_inf(hd));
    if (do_pop) void'(mq.pop_front());
    if (flush) mq.delete();
    else if (do_push) mq.push_back({bus.in_rd, bus.in_data});
    #1;
  endtask

  task automatic test_reset();
    #1 clrn = 1'b0;
    #2;
    checks += 8;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b want 0", bus.wb_valid); end
    if (bus.wb_data !== 32'd0) begin errors++; $display("FAIL reset_wb_data: got %h want 0", bus.wb_data); end
    if (bus.wb_rd !== 5'd0) begin errors++; $display("FAIL reset_wb_rd: got %h want 0", bus.wb_rd); end
    if (bus.fwd_hit !== 1'b0) begin errors++; $display("FAIL reset_fwd_hit: got %b want 0", bus.fwd_hit); end
    if (bus.fwd_data !== 32'd0) begin errors++; $display("FAIL reset_fwd_data: got %h want 0", bus.fwd_data); end
    if (nan_seen !== 1'b0) begin errors++; $display("FAIL reset_nan: got %b want 0", nan_seen); end
    if (inf_seen !== 1'b0) begin errors++; $display("FAIL reset_inf: got %b want 0", inf_seen); end
    #9 clrn = 1'b1;
    $display("reset: released at %0t", $time);
  endtask

  task automatic test_basic();
    set_in(1'b1, 32'h3fc00000, 5'd3, 1'b0);
    bus.fwd_rs = 5'd0;
    tick();
    set_in(1'b0, 32'd0, 5'd0, 1'b0);
    bus.fwd_rs = 5'd3;
    #1;
    checks += 5;
    if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL basic_wb_valid: got %b want 1", bus.wb_valid); end
    if (bus.wb_data !== 32'h3fc00000) begin errors++; $display("FAIL basic_wb_data: got %h want 3fc00000", bus.wb_data); end
    if (bus.wb_rd !== 5'd3) begin errors++; $display("FAIL basic_wb_rd: got %0d want 3", bus.wb_rd); end
    if (bus.fwd_hit !== 1'b1) begin errors++; $display("FAIL basic_fwd_hit: got %b want 1", bus.fwd_hit); end
    if (bus.fwd_data !== 32'h3fc00000) begin errors++; $display("FAIL basic_fwd_data: got %h want 3fc00000", bus.fwd_data); end
    bus.wb_ready = 1'b1;
    tick();
    checks++;
    if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL basic_drained: got %b want 0", bus.wb_valid); end
    $display("basic: push/present/forward/pop of 3fc00000 rd=3");
  endtask

  task automatic test_full();
    logic [31:0] pushed [4];
    for (int i = 0; i < 4; i++) begin
      pushed[i] = $urandom & 32'h3fffffff;
      set_in(1'b1, pushed[i], 5'(10 + i), 1'b0);
      tick();
    end
    set_in(1'b0, 32'd0, 5'd0, 1'b0);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b want 0", bus.in_ready); end
    set_in(1'b1, 32'h12345678, 5'd20, 1'b1);
    #1;
    checks += 2;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_pop_in_ready: got %b want 0", bus.in_ready); end
    if (bus.wb_data !== pushed[0]) begin errors++; $display("FAIL full_head0: got %h want %h", bus.wb_data, pushed[0]); end
    tick();
    set_in(1'b0, 32'd0, 5'd0, 1'b0);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_after_pop_ready: got %b want 1", bus.in_ready); end
    for (int i = 1; i < 4; i++) begin
      checks += 2;
      if (bus.wb_data !== pushed[i]) begin errors++; $display("FAIL full_order_data%0d: got %h want %h", i, bus.wb_data, pushed[i]); end
      if (bus.wb_rd !== 5'(10 + i)) begin errors++; $display("FAIL full_order_rd%0d: got %0d want %0d", i, bus.wb_rd, 10 + i); end
      bus.wb_ready = 1'b1;
      tick();
      bus.wb_ready = 1'b0;
    end
    checks++;
    if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL full_empty: got %b want 0", bus.wb_valid); end
    $display("full: fill to %0d, refused push on pop, drained in order", DEPTH);
  endtask

  task automatic test_fwd();
    logic [31:0] a, b, c;
    a = 32'h40400000; b = 32'h40a00000; c = 32'h41000000;
    bus.fwd_rs = 5'd7;
    set_in(1'b1, a, 5'd7, 1'b0); tick();
    set_in(1'b1, b, 5'd7, 1'b0); tick();
    set_in(1'b0, 32'd0, 5'd0, 1'b1);
    #1;
    checks += 2;
    if (bus.fwd_hit !== 1'b1) begin errors++; $display("FAIL fwd_two_hit: got %b want 1", bus.fwd_hit); end
    if (bus.fwd_data !== b) begin errors++; $display("FAIL fwd_youngest: got %h want %h", bus.fwd_data, b); end
    tick();
    checks += 2;
    if (bus.fwd_data !== b) begin errors++; $display("FAIL fwd_after_pop_a: got %h want %h", bus.fwd_data, b); end
    if (bus.wb_data !== b) begin errors++; $display("FAIL fwd_head_b: got %h want %h", bus.wb_data, b); end
    tick();
    checks += 2;
    if (bus.fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_gone_hit: got %b want 0", bus.fwd_hit); end
    if (bus.fwd_data !== 32'd0) begin errors++; $display("FAIL fwd_gone_data: got %h want 0", bus.fwd_data); end
    set_in(1'b1, c, 5'd7, 1'b0);
    #1;
    checks++;
    if (bus.fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_no_bypass: got %b want 0", bus.fwd_hit); end
    tick();
    set_in(1'b0, 32'd0, 5'd0, 1'b0);
    #1;
    checks++;
    if (bus.fwd_data !== c) begin errors++; $display("FAIL fwd_next_cycle: got %h want %h", bus.fwd_data, c); end
    bus.wb_ready = 1'b1;
    tick();
    $display("fwd: youngest-match and no same-cycle bypass on rd=7");
  endtask

  task automatic test_flags();
    set_in(1'b1, 32'h7fc00000, 5'd1, 1'b0); tick();
    set_in(1'b0, 32'd0, 5'd0, 1'b1);
    #1;
    checks++;
    if (nan_seen !== m_nan) begin errors++; $display("FAIL flag_nan_before: got %b want %b", nan_seen, m_nan); end
    tick();
    checks += 2;
    if (nan_seen !== 1'b1) begin errors++; $display("FAIL flag_nan_set: got %b want 1", nan_seen); end
    if (inf_seen !== m_inf) begin errors++; $display("FAIL flag_inf_untouched: got %b want %b", inf_seen, m_inf); end
    set_in(1'b1, 32'hff800000, 5'd2, 1'b0); tick();
    bus.in_valid = 1'b0; bus.wb_ready = 1'b1; tick();
    checks++;
    if (inf_seen !== 1'b1) begin errors++; $display("FAIL flag_inf_set: got %b want 1", inf_seen); end
    bus.wb_ready = 1'b0; flag_clr = 1'b1; tick(); flag_clr = 1'b0;
    checks += 2;
    if (nan_seen !== 1'b0) begin errors++; $display("FAIL flag_clr_nan: got %b want 0", nan_seen); end
    if (inf_seen !== 1'b0) begin errors++; $display("FAIL flag_clr_inf: got %b want 0", inf_seen); end
    set_in(1'b1, 32'h7f800001, 5'd3, 1'b0); tick();
    set_in(1'b0, 32'd0, 5'd0, 1'b1); flag_clr = 1'b1; tick(); flag_clr = 1'b0;
    checks += 2;
    if (nan_seen !== 1'b1) begin errors++; $display("FAIL flag_set_wins: got %b want 1", nan_seen); end
    if (inf_seen !== 1'b0) begin errors++; $display("FAIL flag_set_wins_inf: got %b want 0", inf_seen); end
    bus.wb_ready = 1'b0;
    $display("flags: nan/inf set, clear, set-beats-clear");
  endtask

  task automatic test_flush();
    flag_clr = 1'b1; set_in(1'b0, 32'd0, 5'd0, 1'b0); tick(); flag_clr = 1'b0;
    set_in(1'b1, 32'h7f800001, 5'd2, 1'b0); tick();
    set_in(1'b1, 32'h3f800000, 5'd4, 1'b0); tick();
    set_in(1'b1, 32'h40000000, 5'd5, 1'b0); tick();
    set_in(1'b1, 32'h41200000, 5'd12, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_in(1'b0, 32'd0, 5'd0, 1'b0);
    bus.fwd_rs = 5'd12;
    #1;
    checks += 4;
    if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL flush_wb_valid: got %b want 0", bus.wb_valid); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b want 1", bus.in_ready); end
    if (nan_seen !== 1'b1) begin errors++; $display("FAIL flush_nan: got %b want 1", nan_seen); end
    if (bus.fwd_hit !== 1'b0) begin errors++; $display("FAIL flush_fwd: got %b want 0", bus.fwd_hit); end
    bus.wb_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost%0d: got %b want 0 (data %h)", i, bus.wb_valid, bus.wb_data); end
    end
    bus.wb_ready = 1'b0;
    $display("flush: pending dropped, same-cycle push dropped, NaN pop recorded");
  endtask

  task automatic test_random();
    logic [RN_W+31:0] he;
    logic [32:0] fw;
    int local_err;
    for (int n = 0; n < 400; n++) begin
      set_in($urandom_range(0, 3) != 0, pick_data(), 5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1);
      flush      = ($urandom_range(0, 29) == 0);
      flag_clr   = ($urandom_range(0, 19) == 0);
      bus.fwd_rs = 5'($urandom_range(0, 7));
      #1;
      he = m_head();
      fw = m_fwd(bus.fwd_rs);
      local_err = errors;
      checks += 8;
      if (bus.in_ready !== (mq.size() != DEPTH)) begin errors++; $display("FAIL rnd_in_ready@%0d: got %b want %b", n, bus.in_ready, mq.size() != DEPTH); end
      if (bus.wb_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_wb_valid@%0d: got %b want %b", n, bus.wb_valid, mq.size() != 0); end
      if (bus.wb_data !== he[31:0]) begin errors++; $display("FAIL rnd_wb_data@%0d: got %h want %h", n, bus.wb_data, he[31:0]); end
      if (bus.wb_rd !== he[RN_W+31:32]) begin errors++; $display("FAIL rnd_wb_rd@%0d: got %0d want %0d", n, bus.wb_rd, he[RN_W+31:32]); end
      if (bus.fwd_hit !== fw[32]) begin errors++; $display("FAIL rnd_fwd_hit@%0d: got %b want %b", n, bus.fwd_hit, fw[32]); end
      if (bus.fwd_data !== fw[31:0]) begin errors++; $display("FAIL rnd_fwd_data@%0d: got %h want %h", n, bus.fwd_data, fw[31:0]); end
      if (nan_seen !== m_nan) begin errors++; $display("FAIL rnd_nan@%0d: got %b want %b", n, nan_seen, m_nan); end
      if (inf_seen !== m_inf) begin errors++; $display("FAIL rnd_inf@%0d: got %b want %b", n, inf_seen, m_inf); end
      $display("rnd %0d: iv=%b d=%h rd=%0d wbr=%b fl=%b clr=%b occ=%0d %s", n, bus.in_valid, bus.in_data,
               bus.in_rd, bus.wb_ready, flush, flag_clr, mq.size(), (errors == local_err) ? "ok" : "bad");
      tick();
    end
    flush = 1'b0;
    flag_clr = 1'b0;
  endtask

  task automatic test_async_reset();
    set_in(1'b1, 32'h7fc00000, 5'd6, 1'b0); tick();
    set_in(1'b1, 32'h3f800000, 5'd7, 1'b0); tick();
    set_in(1'b1, 32'h40000000, 5'd8, 1'b1); tick();
    set_in(1'b0, 32'd0, 5'd0, 1'b1);
    bus.fwd_rs = 5'd7;
    #2 clrn = 1'b0;
    mq.delete();
    m_nan = 1'b0;
    m_inf = 1'b0;
    #1;
    checks += 7;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready: got %b want 1", bus.in_ready); end
    if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL arst_wb_valid: got %b want 0", bus.wb_valid); end
    if (bus.wb_data !== 32'd0) begin errors++; $display("FAIL arst_wb_data: got %h want 0", bus.wb_data); end
    if (bus.fwd_hit !== 1'b0) begin errors++; $display("FAIL arst_fwd_hit: got %b want 0", bus.fwd_hit); end
    if (bus.fwd_data !== 32'd0) begin errors++; $display("FAIL arst_fwd_data: got %h want 0", bus.fwd_data); end
    if (nan_seen !== 1'b0) begin errors++; $display("FAIL arst_nan: got %b want 0", nan_seen); end
    if (inf_seen !== 1'b0) begin errors++; $display("FAIL arst_inf: got %b want 0", inf_seen); end
    #2 clrn = 1'b1;
    set_in(1'b1, 32'h40490fdb, 5'd1, 1'b0);
    tick();
    set_in(1'b0, 32'd0, 5'd0, 1'b0);
    bus.fwd_rs = 5'd1;
    #1;
    checks += 4;
    if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL arst_push_valid: got %b want 1", bus.wb_valid); end
    if (bus.wb_rd !== 5'd1) begin errors++; $display("FAIL arst_push_rd: got %0d want 1", bus.wb_rd); end
    if (bus.wb_data !== 32'h40490fdb) begin errors++; $display("FAIL arst_push_data: got %h want 40490fdb", bus.wb_data); end
    if (bus.fwd_data !== 32'h40490fdb) begin errors++; $display("FAIL arst_push_fwd: got %h want 40490fdb", bus.fwd_data); end
    $display("async_reset: mid-drain reset, then push rd=1 from empty");
  endtask

  initial begin
    set_in(1'b0, 32'd0, 5'd0, 1'b0);
    bus.fwd_rs = 5'd0;
    test_reset();
    test_basic();
    test_full();
    test_fwd();
    test_flags();
    test_flush();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
